toggle_checker: RTL
===================

Name: toggle_checker

Overview:
- Receive-side checker for the per-bit toggle generator.
- Samples a K_NIN-bit bus whose bits must each invert on every clock.
- Acquires lock after K_LOCK consecutive clean cycles, then reports lost toggles:
  - per-bit sticky error mask;
  - saturating error counter;
  - single-cycle error pulse.
- Sits in the same clock domain as the generator; used in self-test and bring-up designs.

Parameters:
K_NIN, 1, width of monitored bus (>=1)
K_LOCK, 4, consecutive clean comparisons required to declare lock (>=1)
K_CNT_W, 8, width of saturating error counter (>=1)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  checker enable; low forces IDLE
i_clr  input  1  synchronous clear of o_err_mask and o_err_cnt
i_in  input  K_NIN  monitored toggle bus
o_locked  output  1  registered; high while in LOCKED
o_err_mask  output  K_NIN  sticky per-bit error flags
o_err_cnt  output  K_CNT_W  saturating count of error events
o_err_pulse  output  1  one-cycle pulse per error event

Behaviour:
- Reset (async, active-low):
  - state=IDLE, prev=0, good_cnt=0.
  - o_locked=0, o_err_mask=0, o_err_cnt=0, o_err_pulse=0.
- prev register loads i_in every cycle, in every state.
- Clean compare: (i_in ^ prev) all ones. Per-bit mismatch m = ~(i_in ^ prev).
- FSM:
  - IDLE: i_en=1 -> PRIME.
  - PRIME: no compare; next ACQUIRE, good_cnt=0.
  - ACQUIRE:
    - clean: good_cnt++; if good_cnt==K_LOCK-1, next LOCKED.
    - any mismatch: good_cnt=0, stay. Not counted as an error.
  - LOCKED:
    - clean: stay.
    - any mismatch = error event:
      - o_err_mask |= m;
      - o_err_cnt += 1, saturating at all-ones;
      - o_err_pulse=1 next cycle;
      - next ACQUIRE, good_cnt=0.
  - Any state with i_en=0 -> IDLE next cycle. o_locked=0. Mask and counter retained. No compare.
- o_locked is registered from the state: high exactly in cycles where state==LOCKED.
- Lock latency: i_en first sampled high at edge 0 with a clean bus.
  - PRIME in cycle 1; compares in cycles 2..K_LOCK+1.
  - o_locked=1 from cycle K_LOCK+2.
- Error latency: mismatch sampled at edge t gives, in cycle t+1:
  - o_err_pulse=1;
  - updated mask and count;
  - o_locked=0.
- o_err_pulse is high for exactly one cycle per event. At most one event per cycle; multiple bad bits in one cycle count as one event.
- i_clr priority: i_clr=1 clears mask and counter at the next edge and overrides a simultaneous error update. The pulse and the state transition still occur.
- Counter saturation: held at 2^K_CNT_W-1; further events still pulse and still set mask bits.
- i_en deassert in the same cycle as a LOCKED mismatch: i_en wins. Go to IDLE, no error event.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of the clock.

Test Plan:
1. K_NIN=4, K_LOCK=4. i_in alternates 4'b0101/4'b1010 from reset; i_en=1 sampled at edge 0 -> o_locked=1 from cycle 6; o_err_cnt=0; o_err_pulse never high.
2. Locked. Bit 2 held one extra cycle at edge t, then resumes the original phase -> o_err_pulse=1 in cycle t+1 only; o_err_mask=4'b0100; o_err_cnt=1; o_locked=0 at t+1; the t+1 mismatch is not counted; o_locked=1 again at t+6.
3. K_CNT_W=2. Five isolated glitches, each after relock -> o_err_cnt saturates at 3; five o_err_pulse events observed.
4. Glitch on bits 0 and 3 in the same cycle, with i_clr=1 at that edge -> o_err_pulse=1; o_err_mask=0; o_err_cnt=0; o_locked=0.
5. Locked; i_en=0 for 3 cycles while i_in is frozen -> o_locked=0 from next cycle; no pulses; mask and count unchanged. i_en=1 again -> relock after K_LOCK+2 cycles.
6. Locked with o_err_cnt=2. Assert i_rst_n=0 between clock edges -> all outputs 0 before the next edge; after release, behaves as scenario 1.

Source files
------------

// File: rtl/toggle_checker.sv
// Receive-side checker for a per-bit toggle generator: every bit of i_in must
// invert on every clock. Locks after K_LOCK clean compares, then flags lost toggles.
module toggle_checker #(
    parameter int K_NIN   = 1,
    parameter int K_LOCK  = 4,
    parameter int K_CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [K_NIN-1:0]   i_in,
    output logic               o_locked,
    output logic [K_NIN-1:0]   o_err_mask,
    output logic [K_CNT_W-1:0] o_err_cnt,
    output logic               o_err_pulse
);

    localparam int GOOD_W = (K_LOCK > 1) ? $clog2(K_LOCK) : 1;
    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(K_LOCK - 1);
    localparam logic [K_CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t             state_q;
    logic [K_NIN-1:0]   prev_q;
    logic [GOOD_W-1:0]  good_q;
    logic               locked_q;
    logic [K_NIN-1:0]   mask_q, mask_d;
    logic [K_CNT_W-1:0] cnt_q, cnt_d;
    logic               pulse_q;

    logic [K_NIN-1:0]   mism;
    logic               clean;
    logic               err_event;

    // A bit that failed to invert since the previous sample is a mismatch.
    assign mism      = ~(i_in ^ prev_q);
    assign clean     = ~|mism;
    // Disable wins over a simultaneous LOCKED mismatch, so i_en gates the event.
    assign err_event = i_en && (state_q == ST_LOCKED) && !clean;

    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (err_event) begin
            mask_d = mask_q | mism;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + K_CNT_W'(1);
            end
        end
        if (i_clr) begin
            mask_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            prev_q  <= i_in;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            pulse_q <= err_event;
            if (!i_en) begin
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
                good_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_PRIME;
                        locked_q <= 1'b0;
                    end
                    // prev_q is not yet meaningful here, so this cycle is not compared.
                    ST_PRIME: begin
                        state_q  <= ST_ACQUIRE;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (clean) begin
                            if (good_q == GOOD_LAST) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                good_q   <= '0;
                            end else begin
                                good_q <= good_q + GOOD_W'(1);
                            end
                        end else begin
                            good_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!clean) begin
                            state_q  <= ST_ACQUIRE;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_locked    = locked_q;
    assign o_err_mask  = mask_q;
    assign o_err_cnt   = cnt_q;
    assign o_err_pulse = pulse_q;

endmodule
